// File: rtl/matrix_result_serializer.sv
// Streams a captured L x N float32 matrix out one element per valid/ready handshake,
// tagging each element with its row/column and flagging the final element of the frame.
module matrix_result_serializer #(
  parameter int L         = 2,
  parameter int N         = 2,
  parameter int COL_MAJOR = 0,
  localparam int RW = (L > 1) ? $clog2(L) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int IW = (L * N > 1) ? $clog2(L * N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [32*L*N-1:0] matrix,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [32*L*N-1:0]   mat_q, mat_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                row_end, col_end, at_last;
  logic [IW-1:0]       sel;
  logic [31:0]         elem;

  assign row_end = (row_q == RW'(L - 1));
  assign col_end = (col_q == CW'(N - 1));
  assign at_last = row_end && col_end;
  assign sel     = IW'(row_q) * IW'(N) + IW'(col_q);

  always_comb begin
    elem = '0;
    for (int k = 0; k < L * N; k++) begin
      if (sel == IW'(k)) elem = mat_q[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          mat_d   = matrix;
          row_d   = '0;
          col_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
          end else if (COL_MAJOR != 0) begin
            // Column-major: rows run fastest, column steps when the row wraps.
            if (row_end) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            if (col_end) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Indices return to zero when idle, so only data and last need gating.
  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign out_data  = out_valid ? elem : '0;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_valid && at_last;

endmodule
